// File: rtl/apb_master_bridge.sv
// APB master bridge: single-outstanding request/response front end driving
// APB SETUP/ACCESS transfers to the GPIO (PSEL[0]) and UART (PSEL[1]) windows.
module apb_master_bridge #(
   parameter int                 ADDR_W    = 32,
   parameter int                 DATA_W    = 32,
   parameter logic [ADDR_W-1:0]  GPIO_BASE = 32'h0000_0000,
   parameter logic [ADDR_W-1:0]  UART_BASE = 32'h0000_1000,
   parameter int                 TIMEOUT   = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [2:0]        req_prot,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [1:0]        PSEL,
   output logic              PENABLE,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PWRITE,
   output logic [DATA_W-1:0] PWDATA,
   output logic [2:0]        PPROT,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   // state  | meaning
   // IDLE   | req_ready high, decode and accept the next request
   // SETUP  | APB setup phase, PSEL asserted, PENABLE low, timer loaded
   // ACCESS | APB access phase, waiting for PREADY or timer terminal count
   // DONE   | one-cycle response pulse, bus idle

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   localparam int               WIN_BITS = 12;
   localparam int               CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

   state_t            state, state_nxt;
   logic [1:0]        sel;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] off_gpio, off_uart;
   logic              hit_gpio, hit_uart, hit_any, cnt_tc;

   // 4 KB windows: the offset from the base must fit in the low 12 bits,
   // which also rejects addresses below the base through wrap-around.
   assign off_gpio = req_addr - GPIO_BASE;
   assign off_uart = req_addr - UART_BASE;
   assign hit_gpio = (off_gpio[ADDR_W-1:WIN_BITS] == '0);
   assign hit_uart = (off_uart[ADDR_W-1:WIN_BITS] == '0);
   assign hit_any  = hit_gpio | hit_uart;
   assign cnt_tc   = (cnt == '0);

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == DONE);
   assign PENABLE   = (state == ACCESS);
   assign PSEL      = ((state == SETUP) || (state == ACCESS)) ? sel : 2'b00;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid) state_nxt = hit_any ? SETUP : DONE;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (PREADY || cnt_tc) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         sel       <= 2'b00;
         cnt       <= '0;
         PADDR     <= '0;
         PWRITE    <= 1'b0;
         PWDATA    <= '0;
         PPROT     <= 3'b000;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (hit_any) begin
                     sel    <= hit_gpio ? 2'b01 : 2'b10;
                     PADDR  <= req_addr;
                     PWRITE <= req_write;
                     PWDATA <= req_wdata;
                     PPROT  <= req_prot;
                  end else begin
                     rsp_rdata <= '0;
                     rsp_err   <= 1'b1;
                  end
               end
            end
            SETUP: cnt <= CNT_LOAD;
            ACCESS: begin
               // PREADY on the final allowed cycle still completes normally
               if (PREADY) begin
                  rsp_err   <= PSLVERR;
                  rsp_rdata <= (PWRITE || PSLVERR) ? '0 : PRDATA;
               end else if (cnt_tc) begin
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: a behavioural APB slave with
// programmable wait states and errors, and a transaction-level expected model.
module tb_apb_master_bridge;

   localparam int          TIMEOUT   = 16;
   localparam logic [31:0] GPIO_BASE = 32'h0000_0000;
   localparam logic [31:0] UART_BASE = 32'h0000_1000;

   typedef struct packed {
      logic [7:0]  lat;
      logic [31:0] rdata;
      logic        err;
      logic [1:0]  sel;
      logic [7:0]  n_setup;
      logic [7:0]  n_access;
      logic [31:0] paddr;
      logic        pwrite;
      logic [31:0] pwdata;
      logic [2:0]  pprot;
      logic        attr_chg;
      logic        bad_en;
      logic [1:0]  done_bus;
      logic        post_ok;
   } obs_t;

   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [2:0]  req_prot = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [1:0]  PSEL;
   logic        PENABLE;
   logic [31:0] PADDR;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [2:0]  PPROT;
   logic [31:0] PRDATA = '0;
   logic        PREADY = 1'b0;
   logic        PSLVERR = 1'b0;

   int checks = 0;
   int passed = 0;

   int          s_waits = 0;
   bit          s_err = 0;
   int          acc_cyc = 0;
   logic [31:0] smem [logic [31:0]];
   logic [31:0] rmem [logic [31:0]];
   logic [31:0] last_hit = '0;

   apb_master_bridge #(
      .ADDR_W(32), .DATA_W(32), .GPIO_BASE(GPIO_BASE), .UART_BASE(UART_BASE), .TIMEOUT(TIMEOUT)
   ) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_prot(req_prot),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   // Slave: drives garbage except on the ACCESS cycle where it becomes ready.
   always @(negedge PCLK) begin
      if (PSEL != 2'b00 && PENABLE === 1'b1) begin
         if (acc_cyc >= s_waits) begin
            PREADY  = 1'b1;
            PSLVERR = s_err;
            if (PWRITE) PRDATA = $urandom;
            else        PRDATA = smem.exists(PADDR) ? smem[PADDR] : ~PADDR;
            if (PWRITE && !s_err) smem[PADDR] = PWDATA;
         end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'($urandom);
            PRDATA  = $urandom;
         end
         acc_cyc++;
      end else begin
         acc_cyc = 0;
         PREADY  = 1'($urandom);
         PSLVERR = 1'($urandom);
         PRDATA  = $urandom;
      end
   end

   task automatic model(input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] p, input int waits, input bit serr, output obs_t e);
      logic [31:0] og, ou;
      bit          to;
      e = '0;
      e.post_ok = 1'b1;
      og = a - GPIO_BASE;
      ou = a - UART_BASE;
      if (og >= 32'h1000 && ou >= 32'h1000) begin
         e.lat = 8'd1;
         e.err = 1'b1;
      end else begin
         to         = (waits >= TIMEOUT);
         e.lat      = to ? 8'(2 + TIMEOUT) : 8'(3 + waits);
         e.sel      = (og < 32'h1000) ? 2'b01 : 2'b10;
         e.n_setup  = 8'd1;
         e.n_access = to ? 8'(TIMEOUT) : 8'(waits + 1);
         e.paddr    = a;
         e.pwrite   = w;
         e.pwdata   = wd;
         e.pprot    = p;
         e.err      = to || serr;
         if (!w && !e.err) e.rdata = rmem.exists(a) ? rmem[a] : ~a;
         if (w && !e.err)  rmem[a] = wd;
         last_hit = a;
      end
   endtask

   task automatic run_txn(input bit w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] p, input int waits, input bit serr,
                          input bit noise, output obs_t o);
      int cyc;
      bit got;
      o = '0;
      got = 0;
      s_waits = waits;
      s_err = serr;
      @(negedge PCLK);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_prot = p;
      @(posedge PCLK); #1;
      cyc = 1;
      while (rsp_valid !== 1'b1 && cyc < 60) begin
         if (noise) begin
            req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
            req_prot = 3'($urandom);
         end else req_valid = 1'b0;
         if (PSEL != 2'b00) begin
            o.sel = o.sel | PSEL;
            if (PENABLE === 1'b1) o.n_access = o.n_access + 8'd1;
            else                  o.n_setup  = o.n_setup + 8'd1;
            if (!got) begin
               o.paddr = PADDR; o.pwrite = PWRITE; o.pwdata = PWDATA; o.pprot = PPROT;
               got = 1;
            end else if ({PADDR, PWRITE, PWDATA, PPROT} !== {o.paddr, o.pwrite, o.pwdata, o.pprot})
               o.attr_chg = 1'b1;
         end else if (PENABLE !== 1'b0) o.bad_en = 1'b1;
         @(posedge PCLK); #1;
         cyc++;
      end
      req_valid = 1'b0;
      o.lat = 8'(cyc);
      o.rdata = rsp_rdata;
      o.err = rsp_err;
      o.done_bus = {PSEL != 2'b00, PENABLE};
      @(posedge PCLK); #1;
      o.post_ok = (req_ready === 1'b1) && (rsp_valid === 1'b0);
   endtask

   task automatic test_reset();
      PRESETn = 1'b0;
      repeat (3) @(posedge PCLK);
      #1;
      checks++;
      if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA, PPROT, rsp_valid, rsp_rdata, rsp_err} !== '0)
         $display("FAIL reset_values got=%h exp=0",
                  {PSEL, PENABLE, PADDR, PWRITE, PWDATA, PPROT, rsp_valid, rsp_rdata, rsp_err});
      else passed++;
      @(negedge PCLK); PRESETn = 1'b1;
      @(posedge PCLK); #1;
      checks++;
      if (req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", req_ready);
      else passed++;
   endtask

   task automatic test_gpio_write();
      obs_t o, e;
      model(1, 32'h2, 32'hF, 3'b010, 0, 0, e);
      run_txn(1, 32'h2, 32'hF, 3'b010, 0, 0, 0, o);
      checks++;
      if (o !== e) $display("FAIL gpio_write got=%h exp=%h", o, e); else passed++;
   endtask

   task automatic test_wait_read();
      obs_t o, e;
      model(0, 32'h2, 32'h1234_5678, 3'b001, 3, 0, e);
      run_txn(0, 32'h2, 32'h1234_5678, 3'b001, 3, 0, 0, o);
      checks++;
      if (o !== e) $display("FAIL wait_read got=%h exp=%h", o, e); else passed++;
      checks++;
      if (o.rdata !== 32'hF) $display("FAIL wait_read_data got=%h exp=0000000f", o.rdata);
      else passed++;
   endtask

   task automatic test_uart();
      obs_t o, e;
      model(1, 32'h1004, 32'hA5A5_0001, 3'b100, 1, 0, e);
      run_txn(1, 32'h1004, 32'hA5A5_0001, 3'b100, 1, 0, 0, o);
      checks++;
      if (o !== e) $display("FAIL uart_write got=%h exp=%h", o, e); else passed++;
      model(0, 32'h1004, 32'h0, 3'b000, 0, 1, e);
      run_txn(0, 32'h1004, 32'h0, 3'b000, 0, 1, 0, o);
      checks++;
      if (o !== e) $display("FAIL uart_slverr got=%h exp=%h", o, e); else passed++;
      model(0, 32'h1004, 32'h0, 3'b000, 2, 0, e);
      run_txn(0, 32'h1004, 32'h0, 3'b000, 2, 0, 0, o);
      checks++;
      if (o !== e) $display("FAIL uart_read got=%h exp=%h", o, e); else passed++;
   endtask

   task automatic test_boundary();
      obs_t o, e;
      logic [31:0] addrs [4] = '{32'h0000_0FFF, 32'h0000_1000, 32'h0000_1FFF, 32'h0000_0000};
      foreach (addrs[i]) begin
         model(1, addrs[i], 32'hB000 + 32'(i), 3'(i), i, 0, e);
         run_txn(1, addrs[i], 32'hB000 + 32'(i), 3'(i), i, 0, 0, o);
         checks++;
         if (o !== e) $display("FAIL boundary_%0d got=%h exp=%h", i, o, e); else passed++;
      end
   endtask

   task automatic test_miss();
      obs_t o, e;
      logic [31:0] addrs [4] = '{32'h0000_3000, 32'h0000_2000, 32'hFFFF_FFFF, 32'h8000_0000};
      foreach (addrs[i]) begin
         model(i[0], addrs[i], $urandom, 3'b111, 0, 0, e);
         run_txn(i[0], addrs[i], 32'hDEAD_0000, 3'b111, 0, 0, 0, o);
         checks++;
         if (o !== e) $display("FAIL miss_%0d got=%h exp=%h", i, o, e); else passed++;
         checks++;
         if (PADDR !== last_hit) $display("FAIL miss_paddr_hold got=%h exp=%h", PADDR, last_hit);
         else passed++;
      end
   endtask

   task automatic test_timeout();
      obs_t o, e;
      model(0, 32'h2, 32'h0, 3'b000, TIMEOUT, 0, e);
      run_txn(0, 32'h2, 32'h0, 3'b000, TIMEOUT, 0, 0, o);
      checks++;
      if (o !== e) $display("FAIL timeout_gpio got=%h exp=%h", o, e); else passed++;
      model(0, 32'h2, 32'h0, 3'b000, TIMEOUT - 1, 0, e);
      run_txn(0, 32'h2, 32'h0, 3'b000, TIMEOUT - 1, 0, 0, o);
      checks++;
      if (o !== e) $display("FAIL timeout_last_cycle got=%h exp=%h", o, e); else passed++;
      model(1, 32'h1008, 32'h77, 3'b011, TIMEOUT + 5, 0, e);
      run_txn(1, 32'h1008, 32'h77, 3'b011, TIMEOUT + 5, 0, 0, o);
      checks++;
      if (o !== e) $display("FAIL timeout_uart got=%h exp=%h", o, e); else passed++;
   endtask

   task automatic test_back_to_back();
      obs_t o, e;
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a, d;
         a = (i % 2 == 0) ? 32'h10 : 32'h1010;
         d = $urandom;
         model(i < 2, a, d, 3'(i + 2), i % 3, 0, e);
         run_txn(i < 2, a, d, 3'(i + 2), i % 3, 0, 1, o);
         checks++;
         if (o !== e) $display("FAIL back_to_back_%0d got=%h exp=%h", i, o, e); else passed++;
      end
   endtask

   task automatic test_random();
      obs_t o, e;
      for (int n = 0; n < 40; n++) begin
         int r, waits;
         bit w, serr, noise;
         logic [31:0] a, d;
         logic [2:0]  p;
         r = $urandom_range(0, 9);
         if (r < 4)       a = GPIO_BASE + 32'($urandom_range(0, 3)) * 4;
         else if (r == 4) a = GPIO_BASE + 32'hFFC;
         else if (r < 8)  a = UART_BASE + 32'($urandom_range(0, 3)) * 4;
         else             a = $urandom | 32'h2000;
         w = 1'($urandom);
         d = $urandom;
         p = 3'($urandom);
         waits = ($urandom_range(0, 7) == 7) ? TIMEOUT + $urandom_range(0, 2) : $urandom_range(0, 4);
         serr = ($urandom_range(0, 5) == 0);
         noise = 1'($urandom);
         model(w, a, d, p, waits, serr, e);
         run_txn(w, a, d, p, waits, serr, noise, o);
         checks++;
         if (o !== e) $display("FAIL random_%0d got=%h exp=%h", n, o, e); else passed++;
      end
   endtask

   task automatic test_reset_mid();
      obs_t o, e;
      bit seen;
      s_waits = 1000;
      s_err = 0;
      @(negedge PCLK);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'h55; req_prot = 3'b101;
      @(posedge PCLK); #1;
      req_valid = 1'b0;
      for (int i = 0; i < 10 && PENABLE !== 1'b1; i++) begin
         @(posedge PCLK); #1;
      end
      checks++;
      if (PENABLE !== 1'b1) $display("FAIL reset_mid_access got=%b exp=1", PENABLE); else passed++;
      #1 PRESETn = 1'b0;
      #1;
      checks++;
      if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA, PPROT, rsp_rdata, rsp_err} !== '0)
         $display("FAIL reset_mid_async got=%h exp=0",
                  {PSEL, PENABLE, PADDR, PWRITE, PWDATA, PPROT, rsp_rdata, rsp_err});
      else passed++;
      last_hit = '0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge PCLK); #1;
         if (rsp_valid !== 1'b0) seen = 1;
      end
      @(negedge PCLK); PRESETn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge PCLK); #1;
         if (rsp_valid !== 1'b0) seen = 1;
      end
      checks++;
      if (seen) $display("FAIL reset_mid_no_rsp got=1 exp=0"); else passed++;
      checks++;
      if (req_ready !== 1'b1) $display("FAIL reset_mid_ready got=%b exp=1", req_ready); else passed++;
      model(0, 32'h8, 32'h0, 3'b000, 1, 0, e);
      run_txn(0, 32'h8, 32'h0, 3'b000, 1, 0, 0, o);
      checks++;
      if (o !== e) $display("FAIL reset_mid_recover got=%h exp=%h", o, e); else passed++;
   endtask

   initial begin
      test_reset();
      test_gpio_write();
      test_wait_read();
      test_uart();
      test_boundary();
      test_miss();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
